// File: rtl/queue_ctrl_pkg.sv
// Shared types for the A* open-list queue controller: FSM state encoding
// and the requester identifiers used by the round-robin arbiter.
package queue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
  } qc_state_t;

  localparam logic REQ_PUSH = 1'b0;
  localparam logic REQ_POP  = 1'b1;

endpackage

// File: rtl/queue_port_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter (push vs pop) with the rr_last flop.
// push_win reports whether a push would be taken this cycle, independent of push_valid.
module rr_arb2
  import queue_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic push_avail,
  input  logic push_valid,
  input  logic pop_cand,
  output logic push_win,
  output logic gnt_push,
  output logic gnt_pop
);

  logic rr_last_q, rr_last_d;

  always_comb begin
    push_win  = 1'b0;
    gnt_push  = 1'b0;
    gnt_pop   = 1'b0;
    rr_last_d = rr_last_q;
    if (en) begin
      // On a tie the requester that was not served last takes the slot.
      push_win = push_avail && (!pop_cand || (rr_last_q == REQ_POP));
      if (push_win && push_valid) begin
        gnt_push  = 1'b1;
        rr_last_d = REQ_PUSH;
      end else if (pop_cand) begin
        gnt_pop   = 1'b1;
        rr_last_d = REQ_POP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_last_q <= REQ_POP;
    else     rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/queue_port_ctrl.sv
// Circular-FIFO controller sequencing a single-port registered-read memory:
// push handshake, request/response pop interface, one memory access per cycle.
module queue_port_ctrl
  import queue_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_req,
  output logic                  pop_gnt,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  input  logic                  pop_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  qc_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   head_q, head_d;
  logic [ADDR_WIDTH-1:0]   tail_q, tail_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    pop_valid_q, pop_valid_d;
  logic [DATA_WIDTH-1:0]   pop_data_q, pop_data_d;

  logic arb_en, pop_cand, push_win, gnt_push, gnt_pop;

  assign full      = (count_q == DEPTH_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign pop_valid = pop_valid_q;
  assign pop_data  = pop_data_q;

  // Flush suppresses every grant in its cycle, so it gates the arbiter.
  assign arb_en   = (state_q == IDLE) && !flush;
  assign pop_cand = pop_req && !empty;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .en         (arb_en),
    .push_avail (!full),
    .push_valid (push_valid),
    .pop_cand   (pop_cand),
    .push_win   (push_win),
    .gnt_push   (gnt_push),
    .gnt_pop    (gnt_pop)
  );

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    pop_valid_d = pop_valid_q;
    pop_data_d  = pop_data_q;
    mem_we      = 1'b0;
    mem_addr    = head_q;
    mem_wdata   = push_data;
    push_ready  = 1'b0;
    pop_gnt     = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      pop_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          push_ready = push_win;
          if (gnt_push) begin
            mem_we   = 1'b1;
            mem_addr = tail_q;
            tail_d   = tail_q + 1'b1;
            count_d  = count_q + 1'b1;
          end else if (gnt_pop) begin
            pop_gnt  = 1'b1;
            head_d   = head_q + 1'b1;
            count_d  = count_q - 1'b1;
            state_d  = RD_WAIT;
          end
        end
        RD_WAIT: begin
          pop_data_d  = mem_rdata;
          pop_valid_d = 1'b1;
          state_d     = HOLD;
        end
        HOLD: begin
          if (pop_ready) begin
            pop_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

endmodule

// File: tb/tb_queue_port_ctrl.sv
// Randomized bench for queue_port_ctrl with a queue-based reference model
// and a behavioural registered-read memory attached to the memory port.
module tb_queue_port_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, push_valid, pop_req, pop_ready;
  logic [7:0] push_data;
  logic       push_ready, pop_gnt, pop_valid, full, empty, mem_we;
  logic [7:0] pop_data, mem_wdata, mem_rdata;
  logic [4:0] count;
  logic [3:0] mem_addr;

  logic [7:0] mem [16];

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  int         phase;
  logic       rr_pop;
  logic [3:0] m_head, m_tail;
  logic [7:0] hold_data, inflight;

  queue_port_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_gnt(pop_gnt), .pop_valid(pop_valid),
    .pop_data(pop_data), .pop_ready(pop_ready),
    .count(count), .full(full), .empty(empty),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic model_reset();
    q.delete();
    phase  = 0;
    rr_pop = 1'b1;
    m_head = '0;
    m_tail = '0;
  endtask

  // One clock cycle: drive inputs, check predicted outputs at the falling
  // edge, then advance the reference model past the rising edge.
  task automatic cycle(input logic pv, input logic [7:0] pd, input logic pr,
                       input logic prdy, input logic fl);
    logic e_rdy, e_pg, e_og;
    logic [5:0] e_flags, a_flags;
    int sz;
    push_valid = pv; push_data = pd; pop_req = pr; pop_ready = prdy; flush = fl;
    sz    = q.size();
    e_rdy = (phase == 0) && !fl && (sz < 16) && !(pr && sz > 0 && !rr_pop);
    e_pg  = e_rdy && pv;
    e_og  = (phase == 0) && !fl && pr && (sz > 0) && !e_pg;
    @(negedge clk);
    e_flags = {e_rdy, e_og, e_pg, phase == 2, sz == 16, sz == 0};
    a_flags = {push_ready, pop_gnt, mem_we, pop_valid, full, empty};
    checks++;
    if (a_flags !== e_flags) begin
      failures++;
      $display("FAIL flags {rdy,gnt,we,pvld,full,empty} got=%b exp=%b t=%0t", a_flags, e_flags, $time);
    end
    checks++;
    if (int'(count) !== sz) begin
      failures++;
      $display("FAIL count got=%0d exp=%0d t=%0t", count, sz, $time);
    end
    if (e_pg) begin
      checks++;
      if ({mem_addr, mem_wdata} !== {m_tail, pd}) begin
        failures++;
        $display("FAIL push_write addr/data got=%h/%h exp=%h/%h", mem_addr, mem_wdata, m_tail, pd);
      end
    end
    if (e_og) begin
      checks++;
      if (mem_addr !== m_head) begin
        failures++;
        $display("FAIL pop_addr got=%h exp=%h", mem_addr, m_head);
      end
    end
    if (phase == 2) begin
      checks++;
      if (pop_data !== hold_data) begin
        failures++;
        $display("FAIL pop_data got=%h exp=%h t=%0t", pop_data, hold_data, $time);
      end
    end
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete(); m_head = '0; m_tail = '0; phase = 0;
    end else begin
      if (phase == 2 && prdy) phase = 0;
      else if (phase == 1) begin phase = 2; hold_data = inflight; end
      if (e_pg) begin q.push_back(pd); m_tail++; rr_pop = 1'b0; end
      else if (e_og) begin inflight = q.pop_front(); m_head++; rr_pop = 1'b1; phase = 1; end
    end
  endtask

  task automatic drain_idle();
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({push_ready, pop_gnt, mem_we, pop_valid, full, empty, count, mem_addr, pop_data}
        !== {6'b100001, 5'd0, 4'd0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b gnt=%b we=%b pv=%b full=%b empty=%b cnt=%0d addr=%h pd=%h",
               push_ready, pop_gnt, mem_we, pop_valid, full, empty, count, mem_addr, pop_data);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    drain_idle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 17; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back_rr();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (count < 5'd4 || count > 5'd6) begin
        failures++;
        $display("FAIL rr_count_range got=%0d exp=4..6", count);
      end
    end
    drain_idle();
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    drain_idle();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    drain_idle();
  endtask

  task automatic test_flush();
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain_idle();
  endtask

  task automatic test_reset_in_hold();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pop_valid !== 1'b1) begin
      failures++;
      $display("FAIL hold_before_reset pop_valid got=%b exp=1", pop_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pop_valid, count, empty} !== {1'b0, 5'd0, 1'b1}) begin
      failures++;
      $display("FAIL async_reset got pv=%b cnt=%0d empty=%b exp pv=0 cnt=0 empty=1", pop_valid, count, empty);
    end
    #1;
    rst = 1'b0;
    model_reset();
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    drain_idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    drain_idle();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0;
    pop_req = 1'b0; pop_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_back_to_back_rr();
    test_wrap();
    test_flush();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
